// File: rtl/out_nu_layer_if.sv
// Handshake, weight-memory and result signals of the output-neuron layer.
// The master side is the timestep controller / weight memory; the slave side is out_nu_layer.
interface out_nu_layer_if #(
    parameter int N_OUT = 8,
    parameter int M_IN  = 784,
    parameter int AW    = 10,
    parameter int W     = 24,
    parameter int WW    = 16
);
    logic                  start_core_img;
    logic                  start_op_nub;
    logic [M_IN-1:0]       spike_ip_nub;
    logic                  w_rd;
    logic [AW-1:0]         w_addr;
    logic [N_OUT*WW-1:0]   w_data;
    logic                  busy;
    logic                  valid_op_nub;
    logic [N_OUT-1:0]      spike_op_nub;
    logic                  first_spike;
    logic [N_OUT*W-1:0]    potentials;
    logic [N_OUT*8-1:0]    count_out;

    modport master (
        output start_core_img, start_op_nub, spike_ip_nub, w_data,
        input  w_rd, w_addr, busy, valid_op_nub, spike_op_nub, first_spike,
               potentials, count_out
    );

    modport slave (
        input  start_core_img, start_op_nub, spike_ip_nub, w_data,
        output w_rd, w_addr, busy, valid_op_nub, spike_op_nub, first_spike,
               potentials, count_out
    );
endinterface

// File: rtl/out_nu_layer.sv
// N_OUT leaky integrate-and-fire output neurons with optional WTA inhibition and refractory periods.
// Define OUT_NU_LAYER_SPIKE_COUNT_EN to build the saturating per-neuron spike counters.
module out_nu_layer #(
    parameter int N_OUT = 8,
    parameter int M_IN  = 784,
    parameter int AW    = 10,
    parameter int W     = 24,
    parameter int WW    = 16,
    parameter int TH    = 15018,
    parameter int LEAK  = 614,
    parameter int PRES  = 0,
    parameter int PMIN  = -2048000,
    parameter int REF   = 30,
    parameter int WTA   = 1
) (
    input  logic           clk,
    input  logic           rst,
    out_nu_layer_if.slave  bus
);

    localparam int SPK_W = 1 << AW;
    localparam int RW    = (REF < 1) ? 1 : $clog2(REF + 1);

    localparam logic [AW-1:0]       LAST_IDX = AW'(M_IN - 1);
    localparam logic signed [W:0]   MAX_X    = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0]   MIN_X    = (W+1)'(PMIN);
    localparam logic signed [W:0]   PRES_X   = (W+1)'(PRES);
    localparam logic signed [W:0]   LEAK_X   = (W+1)'(LEAK);
    localparam logic signed [W-1:0] PRES_P   = W'(PRES);
    localparam logic signed [W-1:0] TH_P     = W'(TH);
    localparam logic [RW-1:0]       REF_L    = RW'(REF);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_LEAK, S_FIRE, S_DONE} state_t;

    state_t                state, state_nx;
    logic                  clr;
    logic [SPK_W-1:0]      spk_q;
    logic [AW-1:0]         idx;
    logic                  rd_q;
    logic signed [W-1:0]   pot      [N_OUT];
    logic [RW-1:0]         refc     [N_OUT];
    logic [N_OUT-1:0]      fire_q;
    logic [N_OUT-1:0]      spike_q;
    logic                  first_q;
    logic                  valid_q;

    logic signed [W:0]     sum      [N_OUT];
    logic signed [W:0]     lsub     [N_OUT];
    logic signed [W:0]     ladd     [N_OUT];
    logic signed [W-1:0]   acc_val  [N_OUT];
    logic signed [W-1:0]   leak_val [N_OUT];
    logic [N_OUT-1:0]      cand;
    logic [N_OUT-1:0]      fire_mask;
    logic                  any_cand;
    logic signed [W-1:0]   best;

    assign clr = bus.start_core_img;

    // NOTE: reset is sampled on the clock edge only; the clear pulse shares the same priority slot.
    always_ff @(posedge clk) begin
        if (!rst || clr) state <= S_IDLE;
        else             state <= state_nx;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start_op_nub) state_nx = S_SCAN;
            S_SCAN:  if (idx == LAST_IDX)  state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_LEAK;
            S_LEAK:  state_nx = S_FIRE;
            S_FIRE:  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.busy         = (state != S_IDLE);
    assign bus.w_rd         = (state == S_SCAN) && spk_q[idx];
    assign bus.w_addr       = idx;
    assign bus.valid_op_nub = valid_q;
    assign bus.spike_op_nub = spike_q;
    assign bus.first_spike  = first_q;

    // Accumulate and leak candidates, computed one bit wider so overflow is visible before clamping.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            sum[j]  = $signed({pot[j][W-1], pot[j]}) +
                      $signed({{(W+1-WW){bus.w_data[j*WW+WW-1]}}, bus.w_data[j*WW +: WW]});
            lsub[j] = $signed({pot[j][W-1], pot[j]}) - LEAK_X;
            ladd[j] = $signed({pot[j][W-1], pot[j]}) + LEAK_X;

            acc_val[j] = sum[j][W-1:0];
            if (refc[j] != '0)      acc_val[j] = PRES_P;
            else if (sum[j] > MAX_X) acc_val[j] = MAX_X[W-1:0];
            else if (sum[j] < MIN_X) acc_val[j] = MIN_X[W-1:0];

            leak_val[j] = PRES_P;
            if ($signed({pot[j][W-1], pot[j]}) > PRES_X)
                leak_val[j] = (lsub[j] < PRES_X) ? PRES_P : lsub[j][W-1:0];
            else if ($signed({pot[j][W-1], pot[j]}) < PRES_X)
                leak_val[j] = (ladd[j] > PRES_X) ? PRES_P : ladd[j][W-1:0];
        end
    end

    // Winner search uses a strict compare so equal potentials resolve to the lowest index.
    always_comb begin
        cand      = '0;
        fire_mask = '0;
        best      = PRES_P;
        for (int j = 0; j < N_OUT; j++)
            cand[j] = (pot[j] >= TH_P) && (refc[j] == '0);
        any_cand = |cand;
        if (WTA != 0) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (cand[j] && (fire_mask == '0 || pot[j] > best)) begin
                    best         = pot[j];
                    fire_mask    = '0;
                    fire_mask[j] = 1'b1;
                end
            end
        end else begin
            fire_mask = cand;
        end
    end

    // NOTE: all sequential state is written with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            spk_q   <= '0;
            idx     <= '0;
            rd_q    <= 1'b0;
            fire_q  <= '0;
            spike_q <= '0;
            first_q <= 1'b0;
            valid_q <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                pot[j]  <= PRES_P;
                refc[j] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            rd_q    <= bus.w_rd;

            if (state == S_IDLE && bus.start_op_nub) begin
                spk_q <= SPK_W'(bus.spike_ip_nub);
                idx   <= '0;
            end
            if (state == S_SCAN && idx != LAST_IDX)
                idx <= idx + AW'(1);

            for (int j = 0; j < N_OUT; j++) begin
                case (state)
                    S_SCAN, S_DRAIN: if (rd_q) pot[j] <= acc_val[j];
                    S_LEAK: begin
                        pot[j] <= leak_val[j];
                        if (refc[j] != '0) refc[j] <= refc[j] - RW'(1);
                    end
                    S_FIRE: begin
                        if (fire_mask[j]) begin
                            pot[j]  <= PRES_P;
                            refc[j] <= REF_L;
                        end else if (WTA != 0 && any_cand) begin
                            pot[j]  <= PRES_P;
                        end
                    end
                    default: ;
                endcase
            end

            if (state == S_FIRE) fire_q <= fire_mask;
            if (state == S_DONE) begin
                valid_q <= 1'b1;
                spike_q <= fire_q;
                if (|fire_q) first_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_pot
        assign bus.potentials[g*W +: W] = pot[g];
    end

`ifdef OUT_NU_LAYER_SPIKE_COUNT_EN
    logic [7:0] cnt [N_OUT];

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            for (int j = 0; j < N_OUT; j++) cnt[j] <= '0;
        end else if (state == S_DONE) begin
            for (int j = 0; j < N_OUT; j++)
                if (fire_q[j] && cnt[j] != 8'hFF) cnt[j] <= cnt[j] + 8'd1;
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
        assign bus.count_out[g*8 +: 8] = cnt[g];
    end
`else
    assign bus.count_out = '0;
`endif

endmodule

// File: tb/tb_out_nu_layer.sv
// Randomised and directed bench for out_nu_layer: a WTA=1 and a WTA=0 instance share stimulus
// and are compared against an integer-level reference model of the neuron rules.
module tb_out_nu_layer;

    localparam int N    = 4;
    localparam int M    = 8;
    localparam int AW   = 3;
    localparam int W    = 16;
    localparam int WW   = 8;
    localparam int TH   = 100;
    localparam int LEAK = 10;
    localparam int PRES = 0;
    localparam int PMIN = -500;
    localparam int REF  = 2;
    localparam int PMAX = 32767;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    out_nu_layer_if #(.N_OUT(N), .M_IN(M), .AW(AW), .W(W), .WW(WW)) bus1 ();
    out_nu_layer_if #(.N_OUT(N), .M_IN(M), .AW(AW), .W(W), .WW(WW)) bus0 ();

    out_nu_layer #(.N_OUT(N), .M_IN(M), .AW(AW), .W(W), .WW(WW), .TH(TH), .LEAK(LEAK),
                   .PRES(PRES), .PMIN(PMIN), .REF(REF), .WTA(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    out_nu_layer #(.N_OUT(N), .M_IN(M), .AW(AW), .W(W), .WW(WW), .TH(TH), .LEAK(LEAK),
                   .PRES(PRES), .PMIN(PMIN), .REF(REF), .WTA(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int n_checks = 0;
    int n_errors = 0;

    // Weight memory shared by both instances; one-cycle read latency, junk when not read.
    int wmem [M][N];
    logic          pend1 = 1'b0, pend0 = 1'b0;
    logic [AW-1:0] apend1 = '0, apend0 = '0;
    int rd_tot1 = 0, rd_tot0 = 0, addr_tot1 = 0, addr_tot0 = 0;

    function automatic logic [N*WW-1:0] row(input logic [AW-1:0] a);
        logic [N*WW-1:0] r;
        for (int j = 0; j < N; j++) r[j*WW +: WW] = WW'(wmem[a][j]);
        return r;
    endfunction

    always @(negedge clk) begin
        pend1  = bus1.w_rd;
        apend1 = bus1.w_addr;
        if (bus1.w_rd) begin
            rd_tot1++;
            addr_tot1 += int'(bus1.w_addr);
        end
    end
    always @(negedge clk) begin
        pend0  = bus0.w_rd;
        apend0 = bus0.w_addr;
        if (bus0.w_rd) begin
            rd_tot0++;
            addr_tot0 += int'(bus0.w_addr);
        end
    end
    always @(posedge clk) bus1.w_data <= pend1 ? row(apend1) : (N*WW)'($urandom);
    always @(posedge clk) bus0.w_data <= pend0 ? row(apend0) : (N*WW)'($urandom);

    // Reference model: index 0 = independent neurons, index 1 = winner-take-all.
    int         m_pot [2][N];
    int         m_ref [2][N];
    int         m_cnt [2][N];
    logic [N-1:0] m_spk [2];
    logic       m_first [2];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clampv(input int v);
        if (v > PMAX) return PMAX;
        if (v < PMIN) return PMIN;
        return v;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_spk[d]   = '0;
            m_first[d] = 1'b0;
            for (int j = 0; j < N; j++) begin
                m_pot[d][j] = PRES;
                m_ref[d][j] = 0;
                m_cnt[d][j] = 0;
            end
        end
    endtask

    task automatic model_step(input logic [M-1:0] s);
        for (int d = 0; d < 2; d++) begin
            logic [N-1:0] f;
            int best_j;
            for (int i = 0; i < M; i++)
                if (s[i])
                    for (int j = 0; j < N; j++)
                        m_pot[d][j] = (m_ref[d][j] != 0) ? PRES : clampv(m_pot[d][j] + wmem[i][j]);
            for (int j = 0; j < N; j++) begin
                if (m_pot[d][j] > PRES)      m_pot[d][j] = (m_pot[d][j] - LEAK < PRES) ? PRES : m_pot[d][j] - LEAK;
                else if (m_pot[d][j] < PRES) m_pot[d][j] = (m_pot[d][j] + LEAK > PRES) ? PRES : m_pot[d][j] + LEAK;
                if (m_ref[d][j] > 0) m_ref[d][j]--;
            end
            f = '0;
            best_j = -1;
            for (int j = 0; j < N; j++) begin
                if (m_pot[d][j] >= TH && m_ref[d][j] == 0) begin
                    if (d == 0) f[j] = 1'b1;
                    else if (best_j < 0 || m_pot[d][j] > m_pot[d][best_j]) best_j = j;
                end
            end
            if (best_j >= 0) begin
                for (int j = 0; j < N; j++) m_pot[d][j] = PRES;
                f[best_j] = 1'b1;
            end
            for (int j = 0; j < N; j++) begin
                if (f[j]) begin
                    m_pot[d][j] = PRES;
                    m_ref[d][j] = REF;
                    if (m_cnt[d][j] < 255) m_cnt[d][j]++;
                end
            end
            m_spk[d] = f;
            if (f != '0) m_first[d] = 1'b1;
        end
    endtask

    task automatic compare(input int d, input logic [N-1:0] spk, input logic [N*W-1:0] pots,
                           input logic first, input logic [N*8-1:0] cnts);
        check($sformatf("d%0d_spikes", d), spk, m_spk[d]);
        check($sformatf("d%0d_first", d), first, m_first[d]);
        for (int j = 0; j < N; j++) begin
            check($sformatf("d%0d_pot%0d", d, j), longint'($signed(pots[j*W +: W])), m_pot[d][j]);
`ifdef OUT_NU_LAYER_SPIKE_COUNT_EN
            check($sformatf("d%0d_cnt%0d", d, j), cnts[j*8 +: 8], m_cnt[d][j]);
`else
            check($sformatf("d%0d_cnt%0d", d, j), cnts[j*8 +: 8], 0);
`endif
        end
    endtask

    task automatic compare_both();
        compare(1, bus1.spike_op_nub, bus1.potentials, bus1.first_spike, bus1.count_out);
        compare(0, bus0.spike_op_nub, bus0.potentials, bus0.first_spike, bus0.count_out);
    endtask

    task automatic drive(input logic st, input logic cl, input logic [M-1:0] s);
        bus1.start_op_nub   = st;  bus0.start_op_nub   = st;
        bus1.start_core_img = cl;  bus0.start_core_img = cl;
        bus1.spike_ip_nub   = s;   bus0.spike_ip_nub   = s;
    endtask

    task automatic set_rows(input int a0, input int a1, input int a2, input int a3);
        for (int i = 0; i < M; i++) begin
            wmem[i][0] = a0; wmem[i][1] = a1; wmem[i][2] = a2; wmem[i][3] = a3;
        end
    endtask

    task automatic do_clear();
        drive(1'b0, 1'b1, '0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0);
        model_clear();
        check("clr_busy", bus1.busy, 0);
    endtask

    // One timestep: start, bounded wait for valid, then compare everything against the model.
    task automatic run_step(input logic [M-1:0] s, input string tag);
        int r1, r0, a1, a0, n, exp_addr;
        logic seen;
        r1 = rd_tot1; r0 = rd_tot0; a1 = addr_tot1; a0 = addr_tot0;
        exp_addr = 0;
        for (int i = 0; i < M; i++) if (s[i]) exp_addr += i;
        drive(1'b1, 1'b0, s);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, M'($urandom));
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            seen = bus1.valid_op_nub;
        end
        check({tag, "_latency"}, n, 12);
        check({tag, "_valid0"}, bus0.valid_op_nub, 1);
        check({tag, "_busy"}, {bus1.busy, bus0.busy}, 0);
        model_step(s);
        compare_both();
        check({tag, "_reads1"}, rd_tot1 - r1, $countones(s));
        check({tag, "_reads0"}, rd_tot0 - r0, $countones(s));
        check({tag, "_addr1"}, addr_tot1 - a1, exp_addr);
        check({tag, "_addr0"}, addr_tot0 - a0, exp_addr);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {bus1.valid_op_nub, bus0.valid_op_nub}, 0);
    endtask

    initial begin
        int v;
        logic [3:0] n3_pat;
        drive(1'b0, 1'b0, '0);
        set_rows(0, 0, 0, 0);
        model_clear();

        // Reset
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_busy", {bus1.busy, bus0.busy}, 0);
        check("rst_valid", {bus1.valid_op_nub, bus0.valid_op_nub}, 0);
        check("rst_wrd", {bus1.w_rd, bus0.w_rd}, 0);
        compare_both();

        // Single spike
        set_rows(10, 20, 30, 120);
        run_step(8'h01, "single");
        check("single_spk1", bus1.spike_op_nub, 4'b1000);
        check("single_first1", bus1.first_spike, 1);

        // Tie
        do_clear();
        set_rows(110, 110, 50, 0);
        run_step(8'h01, "tie");
        check("tie_spk1", bus1.spike_op_nub, 4'b0001);
        check("tie_spk0", bus0.spike_op_nub, 4'b0011);
        check("tie_n2_0", longint'($signed(bus0.potentials[2*W +: W])), 40);

        // Refractory
        do_clear();
        set_rows(10, 20, 30, 120);
        n3_pat = '0;
        for (int t = 0; t < 4; t++) begin
            run_step(8'h01, $sformatf("refr%0d", t));
            n3_pat[t] = bus1.spike_op_nub[3];
        end
        check("refr_pattern", n3_pat, 4'b1001);

        // Saturation at the floor
        do_clear();
        set_rows(-128, -128, -128, -128);
        run_step(8'hFF, "sat");
        check("sat_n0", longint'($signed(bus1.potentials[W-1:0])), -490);
        check("sat_spk", {bus1.spike_op_nub, bus0.spike_op_nub}, 0);

        // Abort mid-scan after a step that left state behind
        do_clear();
        set_rows(10, 20, 30, 120);
        run_step(8'h01, "pre_abort");
        drive(1'b1, 1'b0, 8'h01);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 8'h01);
        @(posedge clk);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 8'hFF);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0);
        model_clear();
        check("abort_busy", {bus1.busy, bus0.busy}, 0);
        compare_both();
        v = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus1.valid_op_nub || bus0.valid_op_nub || bus1.busy || bus0.busy) v++;
        end
        check("abort_quiet", v, 0);
        run_step(8'h01, "fresh");
        do_clear();
        compare_both();

        // Randomised timesteps with occasional clears
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0) do_clear();
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++)
                    wmem[i][j] = int'($urandom_range(0, 120)) - 40;
            run_step(M'($urandom), $sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
